move_list_sequencer: RTL and testbench

//  Sequences one ply's move list through the in-place BRAM move sorter.

---
 rtl/move_list_sequencer.sv | 154 +++++++++++++++
 tb/tb_move_list_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/move_list_sequencer.sv
// Sequences one ply's move list: collect generator moves into the BRAM sorter,
// kick the sort, then stream the sorted moves (best first) to the search.
module move_list_sequencer #(
  parameter int RAM_WIDTH          = 64,
  parameter int MAX_POSITIONS_LOG2 = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          list_start,
  input  logic                          white_to_move_in,
  input  logic                          abort,
  input  logic                          gen_valid,
  input  logic [RAM_WIDTH-1:0]          gen_data,
  input  logic                          gen_last,
  output logic                          gen_ready,
  input  logic                          gen_empty,
  output logic                          srt_wr_addr_init,
  output logic                          srt_wr,
  output logic [RAM_WIDTH-1:0]          srt_wr_data,
  output logic [MAX_POSITIONS_LOG2-1:0] srt_rd_addr,
  input  logic [RAM_WIDTH-1:0]          srt_rd_data,
  output logic                          srt_start,
  output logic                          srt_clear,
  input  logic                          srt_complete,
  output logic                          srt_white_to_move,
  output logic                          out_valid,
  output logic [RAM_WIDTH-1:0]          out_data,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [MAX_POSITIONS_LOG2-1:0] move_count,
  output logic                          overflow,
  output logic                          list_done,
  output logic [3:0]                    state_dbg
);

  localparam int L = MAX_POSITIONS_LOG2;
  localparam logic [L-1:0] CAPACITY = {L{1'b1}};
  localparam logic [L-1:0] ONE      = L'(1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_INIT      = 4'd1,
    S_FILL      = 4'd2,
    S_KICK      = 4'd3,
    S_SORT_WAIT = 4'd4,
    S_RD_ADDR   = 4'd5,
    S_RD_WAIT   = 4'd6,
    S_PRESENT   = 4'd7,
    S_CLEAR     = 4'd8
  } state_t;

  state_t         state, state_nxt;
  logic [L-1:0]   idx;
  logic           aborted;
  logic           accept_beat;
  logic           store_beat;
  logic           abort_live;

  // Handshakes: a beat transfers on the rising edge where valid && ready are
  // both high; a source holds data/last stable while valid && !ready.
  assign accept_beat = (state == S_FILL) && gen_valid && !abort;
  assign store_beat  = accept_beat && (move_count != CAPACITY);
  assign abort_live  = abort && (state != S_IDLE) && (state != S_CLEAR) &&
                       (state != S_KICK);

  assign gen_ready        = (state == S_FILL);
  assign srt_wr_addr_init = (state == S_INIT);
  assign srt_wr           = store_beat;
  assign srt_wr_data      = store_beat ? gen_data : '0;
  assign srt_start        = (state == S_KICK);
  assign srt_clear        = (state == S_CLEAR);
  assign srt_rd_addr      = idx;
  assign list_done        = (state == S_CLEAR) && !srt_complete;
  assign state_dbg        = state;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (list_start) state_nxt = S_INIT;
      S_INIT:      state_nxt = abort ? S_KICK : S_FILL;
      S_FILL: begin
        if (abort || (gen_valid && gen_last) || gen_empty) state_nxt = S_KICK;
      end
      S_KICK:      state_nxt = S_SORT_WAIT;
      S_SORT_WAIT: begin
        if (srt_complete) begin
          if (aborted || abort || (move_count == '0)) state_nxt = S_CLEAR;
          else                                        state_nxt = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        if (abort) state_nxt = srt_complete ? S_CLEAR : S_SORT_WAIT;
        else       state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (abort) state_nxt = srt_complete ? S_CLEAR : S_SORT_WAIT;
        else       state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (abort)          state_nxt = srt_complete ? S_CLEAR : S_SORT_WAIT;
        else if (out_ready) state_nxt = out_last ? S_CLEAR : S_RD_ADDR;
      end
      S_CLEAR:     if (!srt_complete) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      srt_white_to_move <= 1'b0;
      move_count        <= '0;
      overflow          <= 1'b0;
      aborted           <= 1'b0;
      idx               <= '0;
      out_valid         <= 1'b0;
      out_data          <= '0;
      out_last          <= 1'b0;
    end else begin
      if (state == S_IDLE && list_start) begin
        srt_white_to_move <= white_to_move_in;
        move_count        <= '0;
        overflow          <= 1'b0;
        aborted           <= 1'b0;
        idx               <= '0;
      end
      if (store_beat)                 move_count <= move_count + ONE;
      if (accept_beat && !store_beat) overflow   <= 1'b1;
      if (abort_live)                 aborted    <= 1'b1;
      if (state == S_SORT_WAIT)       idx        <= '0;
      // Read data arrives during RD_WAIT; capturing it here makes PRESENT hold it.
      if (state == S_RD_WAIT && !abort) begin
        out_data  <= srt_rd_data;
        out_last  <= (idx == move_count - ONE);
        out_valid <= 1'b1;
      end
      if (state == S_PRESENT) begin
        if (abort) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end else if (out_ready) begin
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          idx       <= idx + ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_move_list_sequencer.sv
// Bench for move_list_sequencer: a behavioural stable sorter model plus a
// table of move lists with hand-ordered expected outputs and abort/reset cases.
module tb_move_list_sequencer;

  localparam int W = 64;
  localparam int L = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          list_start = 1'b0;
  logic          white_to_move_in = 1'b0;
  logic          abort = 1'b0;
  logic          gen_valid = 1'b0;
  logic [W-1:0]  gen_data = '0;
  logic          gen_last = 1'b0;
  logic          gen_ready;
  logic          gen_empty = 1'b0;
  logic          srt_wr_addr_init;
  logic          srt_wr;
  logic [W-1:0]  srt_wr_data;
  logic [L-1:0]  srt_rd_addr;
  logic [W-1:0]  srt_rd_data;
  logic          srt_start;
  logic          srt_clear;
  logic          srt_complete;
  logic          srt_white_to_move;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic          out_ready = 1'b0;
  logic [L-1:0]  move_count;
  logic          overflow;
  logic          list_done;
  logic [3:0]    state_dbg;

  move_list_sequencer #(.RAM_WIDTH(W), .MAX_POSITIONS_LOG2(L)) dut (
    .clk(clk), .reset(reset), .list_start(list_start),
    .white_to_move_in(white_to_move_in), .abort(abort),
    .gen_valid(gen_valid), .gen_data(gen_data), .gen_last(gen_last),
    .gen_ready(gen_ready), .gen_empty(gen_empty),
    .srt_wr_addr_init(srt_wr_addr_init), .srt_wr(srt_wr),
    .srt_wr_data(srt_wr_data), .srt_rd_addr(srt_rd_addr),
    .srt_rd_data(srt_rd_data), .srt_start(srt_start), .srt_clear(srt_clear),
    .srt_complete(srt_complete), .srt_white_to_move(srt_white_to_move),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .move_count(move_count), .overflow(overflow),
    .list_done(list_done), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- sorter model ----------------
  typedef logic [W-1:0] mem_t [8];
  mem_t smem;
  int   wr_ptr;
  int   busy;
  logic start_q;

  function automatic int ev_of(input logic [W-1:0] d);
    return int'($signed(d[15:0]));
  endfunction

  function automatic mem_t sorted(input mem_t m, input int n, input logic white);
    mem_t r;
    logic [W-1:0] t;
    int j;
    r = m;
    for (int i = 1; i < n; i++) begin
      t = r[i];
      j = i;
      while (j > 0 && (white ? (ev_of(r[j-1]) < ev_of(t)) : (ev_of(r[j-1]) > ev_of(t)))) begin
        r[j] = r[j-1];
        j--;
      end
      r[j] = t;
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= 0;
      busy         <= 0;
      srt_complete <= 1'b0;
      srt_rd_data  <= '0;
      start_q      <= 1'b0;
    end else begin
      start_q     <= srt_start;
      srt_rd_data <= smem[srt_rd_addr];
      if (srt_wr_addr_init) wr_ptr <= 0;
      else if (srt_wr && wr_ptr < 8) begin
        smem[wr_ptr] <= srt_wr_data;
        wr_ptr       <= wr_ptr + 1;
      end
      if (srt_start && !start_q) busy <= 3;
      else if (busy != 0) begin
        busy <= busy - 1;
        if (busy == 1) begin
          smem         <= sorted(smem, wr_ptr, srt_white_to_move);
          srt_complete <= 1'b1;
        end
      end
      if (srt_clear) srt_complete <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt, start_cnt, clear_cnt, valid_cnt, wr_out, accepted;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int idx, input int ev);
    return {32'(idx + 1), 16'h0, 16'(ev)};
  endfunction

  task automatic tick();
    @(negedge clk);
    if (list_done) done_cnt++;
    if (srt_start) start_cnt++;
    if (srt_clear) clear_cnt++;
    if (out_valid) valid_cnt++;
    if (srt_wr && !gen_ready) wr_out++;
  endtask

  task automatic clear_counters();
    done_cnt = 0; start_cnt = 0; clear_cnt = 0; valid_cnt = 0; wr_out = 0; accepted = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gen_ready"}, gen_ready, 0);
    check({tag, "_wr_init"}, srt_wr_addr_init, 0);
    check({tag, "_srt_wr"}, srt_wr, 0);
    check({tag, "_wr_data"}, srt_wr_data, 0);
    check({tag, "_rd_addr"}, srt_rd_addr, 0);
    check({tag, "_srt_start"}, srt_start, 0);
    check({tag, "_srt_clear"}, srt_clear, 0);
    check({tag, "_white"}, srt_white_to_move, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_move_count"}, move_count, 0);
    check({tag, "_overflow"}, overflow, 0);
    check({tag, "_list_done"}, list_done, 0);
    check({tag, "_state"}, state_dbg, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic white;
    int   n;
    int   ev[10];
    int   n_exp;
    int   ord[7];
    logic ovf;
    int   stall;
  } vec_t;
  vec_t vecs[5];

  task automatic load_vectors();
    vecs[0].white = 1; vecs[0].n = 5; vecs[0].ev = '{3, -5, 9, 0, 9, 0, 0, 0, 0, 0};
    vecs[0].n_exp = 5; vecs[0].ord = '{2, 4, 0, 3, 1, 0, 0}; vecs[0].ovf = 0; vecs[0].stall = 0;
    vecs[1].white = 0; vecs[1].n = 5; vecs[1].ev = '{3, -5, 9, 0, 9, 0, 0, 0, 0, 0};
    vecs[1].n_exp = 5; vecs[1].ord = '{1, 3, 0, 2, 4, 0, 0}; vecs[1].ovf = 0; vecs[1].stall = 0;
    vecs[2].white = 1; vecs[2].n = 0; vecs[2].ev = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].n_exp = 0; vecs[2].ord = '{0, 0, 0, 0, 0, 0, 0}; vecs[2].ovf = 0; vecs[2].stall = 0;
    vecs[3].white = 1; vecs[3].n = 10; vecs[3].ev = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100};
    vecs[3].n_exp = 7; vecs[3].ord = '{6, 5, 4, 3, 2, 1, 0}; vecs[3].ovf = 1; vecs[3].stall = 0;
    vecs[4].white = 0; vecs[4].n = 6; vecs[4].ev = '{7, -2, 7, 1, -9, 4, 0, 0, 0, 0};
    vecs[4].n_exp = 6; vecs[4].ord = '{4, 1, 3, 5, 0, 2, 0}; vecs[4].ovf = 0; vecs[4].stall = 30;
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_and_fill(input int v, input int n_feed, input bit use_empty);
    int t;
    list_start = 1'b1;
    white_to_move_in = vecs[v].white;
    tick();
    list_start = 1'b0;
    for (t = 0; t < 20 && !gen_ready; t++) tick();
    if (!gen_ready) check("gen_ready_timeout", 0, 1);
    if (use_empty) begin
      gen_empty = 1'b1;
      tick();
      gen_empty = 1'b0;
    end else begin
      for (int i = 0; i < n_feed; i++) begin
        gen_valid = 1'b1;
        gen_data  = mk(i, vecs[v].ev[i]);
        gen_last  = (i == vecs[v].n - 1);
        tick();
      end
    end
    gen_valid = 1'b0;
    gen_last  = 1'b0;
    gen_data  = '0;
  endtask

  task automatic drain(input int stall, input int abort_after);
    logic stalled;
    logic [W-1:0] pd;
    logic pl;
    bit aborted_here;
    logic [W-1:0] e;
    stalled = 1'b0; pd = '0; pl = 1'b0; aborted_here = 0;
    for (int t = 0; t < 600 && done_cnt == 0; t++) begin
      out_ready = 1'b0;
      if (out_valid && !aborted_here) begin
        if (stalled) begin
          check("stall_data", out_data, pd);
          check("stall_last", out_last, pl);
        end
        if (accepted == abort_after) begin
          abort = 1'b1;
          aborted_here = 1;
          valid_cnt = 0;
        end else if ($urandom_range(99) >= stall) begin
          out_ready = 1'b1;
          if (exp_q.size() == 0) check("extra_output", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_data", out_data, e);
            check("out_last", out_last, exp_q.size() == 0);
          end
          accepted++;
        end
        stalled = !out_ready && !aborted_here;
        pd = out_data;
        pl = out_last;
      end else begin
        stalled = 1'b0;
      end
      tick();
      abort = 1'b0;
    end
    out_ready = 1'b0;
    if (done_cnt == 0) check("list_done_timeout", 0, 1);
  endtask

  task automatic run_vec(input int v);
    int i;
    clear_counters();
    exp_q = {};
    for (int k = 0; k < vecs[v].n_exp; k++) begin
      i = vecs[v].ord[k];
      exp_q.push_back(mk(i, vecs[v].ev[i]));
    end
    start_and_fill(v, vecs[v].n, vecs[v].n == 0);
    drain(vecs[v].stall, -1);
    tick();
    check("n_out", accepted, vecs[v].n_exp);
    check("exp_left", exp_q.size(), 0);
    check("move_count", move_count, vecs[v].n_exp);
    check("overflow", overflow, vecs[v].ovf);
    check("white_latch", srt_white_to_move, vecs[v].white);
    check("start_pulses", start_cnt, 1);
    check("clear_seen", clear_cnt > 0, 1);
    check("done_pulses", done_cnt, 1);
    check("wr_outside_fill", wr_out, 0);
    check("back_to_idle", state_dbg, 0);
    if (vecs[v].n_exp == 0) check("no_valid_empty", valid_cnt, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    load_vectors();
    clear_counters();
    repeat (3) tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    for (int v = 0; v < 5; v++) run_vec(v);

    // abort while presenting, after two moves have been taken
    clear_counters();
    exp_q = {};
    for (int k = 0; k < 5; k++) exp_q.push_back(mk(vecs[0].ord[k], vecs[0].ev[vecs[0].ord[k]]));
    start_and_fill(0, 5, 0);
    drain(0, 2);
    tick();
    check("abort_pres_accepted", accepted, 2);
    check("abort_pres_valid_after", valid_cnt, 0);
    check("abort_pres_done", done_cnt, 1);
    check("abort_pres_idle", state_dbg, 0);

    // abort during fill after two beats
    clear_counters();
    exp_q = {};
    start_and_fill(1, 2, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    drain(0, -1);
    tick();
    check("abort_fill_valid", valid_cnt, 0);
    check("abort_fill_start", start_cnt, 1);
    check("abort_fill_done", done_cnt, 1);
    check("abort_fill_count", move_count, 2);

    // reset in the middle of a fill
    clear_counters();
    start_and_fill(0, 2, 0);
    check("pre_reset_white", srt_white_to_move, 1);
    reset = 1'b1;
    tick();
    check_all_zero("mid_reset");
    reset = 1'b0;
    tick();
    check_all_zero("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
